// File: rtl/enc_pkg.sv
// Shared encoder types: instruction formats, FSM states, RV32I opcode constants.
package enc_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_LI   = 3'd5,
    FMT_RSV6 = 3'd6,
    FMT_RSV7 = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_LI_HI = 2'd2
  } state_e;

  localparam logic [6:0]  OP_LUI    = 7'h37;
  localparam logic [6:0]  OP_IMM    = 7'h13;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] addi_word(input logic [11:0] imm12,
                                            input logic [4:0]  rs1,
                                            input logic [4:0]  rd);
    return {imm12, rs1, 3'b000, rd, OP_IMM};
  endfunction

endpackage

// File: rtl/enc_field_pack.sv
// Combinational RV32I field packer; LI yields one or two beats (LUI then ADDI).
// Immediate range flags only exist when ENC_RANGE_CHECK_EN is defined.
module enc_field_pack
  import enc_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] beat0,
  output logic [31:0] beat1,
  output logic        two_beat,
  output logic        err
);

  logic        illegal;
  logic [19:0] hi20;

  // (imm + 0x800) >> 12 without a 32-bit adder: the rounding carry is imm[11].
  assign hi20 = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    beat0    = RESET_INSTR;
    beat1    = RESET_INSTR;
    two_beat = 1'b0;
    illegal  = 1'b0;
    case (fmt_e'(fmt))
      FMT_I: beat0 = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: beat0 = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: beat0 = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: beat0 = {imm[31:12], rd, opcode};
      FMT_J: beat0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_LI: begin
        if (hi20 == 20'd0) begin
          beat0 = addi_word(imm[11:0], 5'd0, rd);
        end else begin
          beat0    = {hi20, rd, OP_LUI};
          beat1    = addi_word(imm[11:0], rd, rd);
          two_beat = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic range_bad;

  always_comb begin
    range_bad = 1'b0;
    case (fmt_e'(fmt))
      FMT_I, FMT_S: range_bad = imm[31:11] != {21{imm[11]}};
      FMT_B:        range_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_J:        range_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
      FMT_U:        range_bad = imm[11:0] != 12'd0;
      default:      range_bad = 1'b0;
    endcase
  end

  assign err = illegal | range_bad;
`else
  assign err = illegal;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a one-entry output register; out_valid 1 cycle after accept.
// LI may expand to LUI+ADDI; in_ready drops while the ADDI is pending or the held beat stalls.
// Optional immediate range flagging via ENC_RANGE_CHECK_EN.
module instr_encoder
  import enc_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  state_e      state_q, state_d;
  logic [31:0] pend_q;
  logic [31:0] beat0, beat1;
  logic        two_beat, err0;
  logic [31:0] instr_d;
  logic        err_d;
  logic        accept;

  enc_field_pack #(.RESET_INSTR(RESET_INSTR)) u_pack (
    .fmt      (in_fmt),
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .beat0    (beat0),
    .beat1    (beat1),
    .two_beat (two_beat),
    .err      (err0)
  );

  assign in_ready  = rst_n && ((state_q == ST_EMPTY) || (state_q == ST_ONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != ST_EMPTY);

  always_comb begin
    state_d = state_q;
    instr_d = out_instr;
    err_d   = out_err;
    case (state_q)
      ST_EMPTY, ST_ONE: begin
        if (accept) begin
          state_d = two_beat ? ST_LI_HI : ST_ONE;
          instr_d = beat0;
          err_d   = err0;
        end else if (state_q == ST_ONE && out_ready) begin
          state_d = ST_EMPTY;
          instr_d = RESET_INSTR;
          err_d   = 1'b0;
        end
      end
      ST_LI_HI: begin
        if (out_ready) begin
          state_d = ST_ONE;
          instr_d = pend_q;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        instr_d = RESET_INSTR;
        err_d   = 1'b0;
      end
    endcase
  end

  // The ADDI is snapshotted at accept so later input changes cannot alter beat 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      out_instr <= RESET_INSTR;
      out_err   <= 1'b0;
      pend_q    <= RESET_INSTR;
    end else begin
      state_q   <= state_d;
      out_instr <= instr_d;
      out_err   <= err_d;
      if (accept) pend_q <= beat1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized traffic against a beat-queue model.
module tb_instr_encoder;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w[$];
  logic        exp_e[$];

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Reference: beats an RV32I assembler would produce, range rules as signed intervals.
  function automatic void ref_enc(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [31:0] imm, output int n, output logic [31:0] w0,
                                  output logic [31:0] w1, output logic e0);
    longint si;
    logic [31:0] hi;
    si = longint'($signed(imm));
    n  = 1;
    w0 = 32'h13;
    w1 = 32'h0;
    e0 = 1'b0;
    case (f)
      3'd0: begin
        w0 = {imm[11:0], s1, f3, d, op};
        e0 = RC && (si < -2048 || si > 2047);
      end
      3'd1: begin
        w0 = {imm[11:5], s2, s1, f3, imm[4:0], op};
        e0 = RC && (si < -2048 || si > 2047);
      end
      3'd2: begin
        w0 = {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], op};
        e0 = RC && (si < -4096 || si > 4095 || imm[0]);
      end
      3'd3: begin
        w0 = {imm[31:12], d, op};
        e0 = RC && ((imm % 32'd4096) != 32'd0);
      end
      3'd4: begin
        w0 = {imm[20], imm[10:1], imm[11], imm[19:12], d, op};
        e0 = RC && (si < -1048576 || si > 1048575 || imm[0]);
      end
      3'd5: begin
        hi = (imm + 32'h800) >> 12;
        if (hi == 32'd0) begin
          w0 = {imm[11:0], 5'd0, 3'b000, d, 7'h13};
        end else begin
          n  = 2;
          w0 = {hi[19:0], d, 7'h37};
          w1 = {imm[11:0], d, 3'b000, d, 7'h13};
        end
      end
      default: e0 = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    int v;
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: r = $urandom();
      1: begin v = int'($urandom_range(0, 8191)) - 4096; r = 32'(v); end
      2: begin r = $urandom(); r = r & 32'hFFFF_F000; end
      3: begin v = int'($urandom_range(0, 4194303)) - 2097152; r = 32'(v) & 32'hFFFF_FFFE; end
      default: begin v = int'($urandom_range(0, 4095)) - 2048; r = 32'(v) + 32'h0000_0800; end
    endcase
    return r;
  endfunction

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_opcode = op;
    in_funct3 = f3;
    in_rd     = d;
    in_rs1    = s1;
    in_rs2    = s2;
    in_imm    = imm;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h want 00000013", out_instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", out_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_i_fmt();
    @(negedge clk);
    out_ready = 1'b1;
    set_req(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL i_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL i_valid got %0b want 1", out_valid); end
    checks++; if (out_instr !== 32'hFFF3_0293) begin errors++; $display("FAIL i_instr got %h want fff30293", out_instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL i_err got %0b want 0", out_err); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h13) begin
      errors++; $display("FAIL i_empty_after got valid=%0b instr=%h want 0/00000013", out_valid, out_instr);
    end
  endtask

  task automatic test_li_two_beat();
    logic [31:0] lui_w, addi_w, recon;
    @(negedge clk);
    out_ready = 1'b1;
    set_req(3'd5, 7'h7F, 3'd7, 5'd1, 5'd9, 5'd9, 32'h1234_5FFF);
    @(negedge clk);
    set_req(3'd0, 7'h13, 3'd0, 5'd3, 5'd3, 5'd0, 32'h1);
    #1;
    lui_w = out_instr;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h1234_60B7) begin
      errors++; $display("FAIL li_lui got valid=%0b instr=%h want 1/123460b7", out_valid, out_instr);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL li_in_ready_lui got %0b want 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    addi_w = out_instr;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFFF0_8093) begin
      errors++; $display("FAIL li_addi got valid=%0b instr=%h want 1/fff08093", out_valid, out_instr);
    end
    recon = {lui_w[31:12], 12'h000} + {{20{addi_w[31]}}, addi_w[31:20]};
    checks++; if (recon !== 32'h1234_5FFF) begin errors++; $display("FAIL li_value got %h want 12345fff", recon); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL li_done got %0b want 0", out_valid); end
  endtask

  task automatic test_li_single();
    @(negedge clk);
    out_ready = 1'b1;
    set_req(3'd5, 7'h00, 3'd0, 5'd2, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0050_0113) begin
      errors++; $display("FAIL li1_instr got valid=%0b instr=%h want 1/00500113", out_valid, out_instr);
    end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL li1_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_stall();
    int n;
    logic [31:0] wa, wb, w1;
    logic e;
    ref_enc(3'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd4, 32'h10, n, wa, w1, e);
    ref_enc(3'd0, 7'h13, 3'd0, 5'd7, 5'd8, 5'd0, 32'h7FF, n, wb, w1, e);
    @(negedge clk);
    out_ready = 1'b0;
    set_req(3'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd4, 32'h10);
    @(negedge clk);
    set_req(3'd0, 7'h13, 3'd0, 5'd7, 5'd8, 5'd0, 32'h7FF);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_instr !== wa || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc%0d got v=%0b instr=%h rdy=%0b want 1/%h/0", i, out_valid, out_instr, in_ready, wa);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (out_instr !== wa || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release got instr=%h rdy=%0b want %h/1", out_instr, in_ready, wa);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_instr !== wb) begin
      errors++; $display("FAIL stall_next got v=%0b instr=%h want 1/%h", out_valid, out_instr, wb);
    end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_b_err_and_illegal();
    @(negedge clk);
    out_ready = 1'b1;
    set_req(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h0000_1001);
    @(negedge clk);
    set_req(3'd7, 7'h33, 3'd1, 5'd4, 5'd4, 5'd4, 32'h0);
    #1;
    checks++; if (out_instr !== 32'h8020_8063) begin errors++; $display("FAIL b_instr got %h want 80208063", out_instr); end
    checks++; if (out_err !== RC) begin errors++; $display("FAIL b_err got %0b want %0b", out_err, RC); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h13 || out_err !== 1'b1) begin
      errors++; $display("FAIL illegal got v=%0b instr=%h err=%0b want 1/00000013/1", out_valid, out_instr, out_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_li();
    int seen;
    @(negedge clk);
    out_ready = 1'b0;
    set_req(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h1234_60B7) begin
      errors++; $display("FAIL rst_li_setup got v=%0b instr=%h want 1/123460b7", out_valid, out_instr);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_li_in_ready got %0b want 0", in_ready); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h13) begin
      errors++; $display("FAIL rst_li_clear got v=%0b instr=%h want 0/00000013", out_valid, out_instr);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_li_no_addi got %0d beats want 0", seen); end
  endtask

  task automatic test_random();
    int n, budget;
    logic [31:0] w0, w1;
    logic e0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_fmt    = 3'($urandom_range(0, 7));
      in_opcode = 7'($urandom());
      in_funct3 = 3'($urandom());
      in_rd     = 5'($urandom());
      in_rs1    = 5'($urandom());
      in_rs2    = 5'($urandom());
      in_imm    = rand_imm();
      #1;
      checks++;
      if (in_ready !== ((exp_w.size() == 0) || (exp_w.size() == 1 && out_ready))) begin
        errors++; $display("FAIL rnd_in_ready cyc%0d got %0b queued=%0d", cyc, in_ready, exp_w.size());
      end
      checks++;
      if (out_valid !== (exp_w.size() != 0)) begin
        errors++; $display("FAIL rnd_valid cyc%0d got %0b want %0b", cyc, out_valid, exp_w.size() != 0);
      end else if (out_valid === 1'b1 && (out_instr !== exp_w[0] || out_err !== exp_e[0])) begin
        errors++; $display("FAIL rnd_beat cyc%0d got %h/%0b want %h/%0b", cyc, out_instr, out_err, exp_w[0], exp_e[0]);
      end
      if (out_valid === 1'b1 && out_ready && exp_w.size() != 0) begin
        void'(exp_w.pop_front());
        void'(exp_e.pop_front());
      end
      if (in_valid && in_ready === 1'b1) begin
        ref_enc(in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm, n, w0, w1, e0);
        exp_w.push_back(w0);
        exp_e.push_back(e0);
        if (n == 2) begin
          exp_w.push_back(w1);
          exp_e.push_back(1'b0);
        end
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while (out_valid === 1'b1 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain got valid=%0b after %0d cycles", out_valid, budget); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_fmt    = 3'd0;
    in_opcode = 7'd0;
    in_funct3 = 3'd0;
    in_rd     = 5'd0;
    in_rs1    = 5'd0;
    in_rs2    = 5'd0;
    in_imm    = 32'd0;
    test_reset();
    test_i_fmt();
    test_li_two_beat();
    test_li_single();
    test_stall();
    test_b_err_and_illegal();
    test_reset_mid_li();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
